// File: rtl/branch_predict_unit.sv
// Gshare branch predictor: 2-bit PHT indexed by PC^GHR, with D->E->M
// prediction tracking, retired-history GHR, flush on mispredict, stats.
// Ports: clka, rst (async high), stall, branchD, pcD, actual_takeM ->
//   pred_takeD, pred_takeM, branchM, mispredM, branch_cnt, mispred_cnt.
module branch_predict_unit #(
  parameter int GHR_W = 8
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchD,
  input  logic [31:0] pcD,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_takeM,
  output logic        branchM,
  output logic        mispredM,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int DEPTH = 2 ** GHR_W;

  logic [1:0]       r_pht [DEPTH];
  logic [GHR_W-1:0] r_ghr;
  logic             r_e_vld;
  logic             r_e_pred;
  logic [GHR_W-1:0] r_e_idx;
  logic             r_m_vld;
  logic             r_m_pred;
  logic [GHR_W-1:0] r_m_idx;
  logic [15:0]      r_br_cnt;
  logic [15:0]      r_mis_cnt;

  logic [GHR_W-1:0] w_idx_d;
  logic             w_upd;
  logic             w_flush;
  logic [1:0]       w_ctr;
  logic [1:0]       w_ctr_nxt;
  logic             w_unused;

  assign w_unused = ^{pcD[31:GHR_W+2], pcD[1:0]};

  assign w_idx_d    = pcD[GHR_W+1:2] ^ r_ghr;
  // Read is taken from the current array, so a same-cycle M write is
  // not visible here until the next cycle.
  assign pred_takeD = branchD & r_pht[w_idx_d][1];

  assign branchM    = r_m_vld;
  assign pred_takeM = r_m_pred;
  assign mispredM   = r_m_vld & (actual_takeM ^ r_m_pred);

  assign w_upd   = r_m_vld & ~stall;
  assign w_flush = mispredM;

  assign branch_cnt  = r_br_cnt;
  assign mispred_cnt = r_mis_cnt;

  always_comb begin
    w_ctr     = r_pht[r_m_idx];
    w_ctr_nxt = w_ctr;
    if (actual_takeM) begin
      if (w_ctr != 2'b11) w_ctr_nxt = w_ctr + 2'b01;
    end else begin
      if (w_ctr != 2'b00) w_ctr_nxt = w_ctr - 2'b01;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pht[i] <= 2'b01;
    end else if (w_upd) begin
      r_pht[r_m_idx] <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[GHR_W-2:0], actual_takeM};
    end
  end

  // Anything younger than a mispredicted branch is wrong-path work.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_e_vld  <= 1'b0;
      r_e_pred <= 1'b0;
      r_e_idx  <= '0;
      r_m_vld  <= 1'b0;
      r_m_pred <= 1'b0;
      r_m_idx  <= '0;
    end else if (!stall) begin
      r_e_vld  <= branchD & ~w_flush;
      r_e_pred <= pred_takeD;
      r_e_idx  <= w_idx_d;
      r_m_vld  <= r_e_vld & ~w_flush;
      r_m_pred <= r_e_pred;
      r_m_idx  <= r_e_idx;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (!stall) begin
      if (r_m_vld && r_br_cnt != 16'hFFFF)
        r_br_cnt <= r_br_cnt + 16'd1;
      if (w_flush && r_mis_cnt != 16'hFFFF)
        r_mis_cnt <= r_mis_cnt + 16'd1;
    end
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter GHR_W, default 8, SHALL set global history width and PHT index width; PHT depth SHALL be 2**GHR_W.
REQ-002 clka  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 stall  input  1  SHALL, when high, freeze all pipeline tracking registers, the PHT, the GHR and the counters.
REQ-005 branchD  input  1  SHALL mark a conditional branch in decode.
REQ-006 pcD  input  32  SHALL carry the decode-stage PC.
REQ-007 actual_takeM  input  1  SHALL carry the resolved branch outcome in memory stage.
REQ-008 pred_takeD  output  1  SHALL carry the decode-stage prediction.
REQ-009 pred_takeM  output  1  SHALL carry the prediction that travelled with the memory-stage branch.
REQ-010 branchM  output  1  SHALL mark a valid branch in memory stage.
REQ-011 mispredM  output  1  SHALL flag a memory-stage misprediction.
REQ-012 branch_cnt  output  16  SHALL count resolved branches.
REQ-013 mispred_cnt  output  16  SHALL count mispredictions.

Function
REQ-014 Index SHALL be idxD = pcD[GHR_W+1:2] XOR ghr.
REQ-015 PHT entries SHALL be 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 pred_takeD SHALL equal branchD AND pht[idxD][1], combinationally.
REQ-017 D->E and E->M registers SHALL carry {valid=branchD, pred, idx}, one stage per unstalled cycle; branch reaches M two cycles after D.
REQ-018 branchM, pred_takeM SHALL be the valid and pred fields of the M register.
REQ-019 mispredM SHALL equal branchM AND (actual_takeM XOR pred_takeM), combinationally.
REQ-020 When mispredM is high and stall low, the next-cycle E and M register valid bits SHALL be cleared (wrong-path flush); idx/pred contents are don't-care.
REQ-021 When branchM is high and stall low, pht[idxM] SHALL increment (actual taken, saturating at 11) or decrement (not taken, saturating at 00).
REQ-022 On the same update, ghr SHALL become {ghr[GHR_W-2:0], actual_takeM}; the GHR is retired history, never speculatively updated.
REQ-023 Same-cycle read at idxD and write at idxM to the same entry SHALL return the pre-update value (no bypass).
REQ-024 branch_cnt SHALL increment per unstalled branchM cycle; mispred_cnt per unstalled mispredM cycle; both SHALL saturate at 16'hFFFF.
REQ-025 No update or counter change SHALL occur while stall is high; combinational outputs remain valid during stall.

Reset
REQ-026 Reset SHALL set every PHT entry to 01, ghr to 0, all pipeline valid/pred/idx fields to 0, both counters to 0.
REQ-027 Consequently pred_takeM, branchM, mispredM SHALL be 0 during and after reset until a branch reaches M.
REQ-028 Reset asserted mid-flight SHALL discard in-flight branches without PHT or counter update.

Verification
REQ-029 Reset, branchD=1 pcD=0x00000040 -> pred_takeD=0; two cycles later branchM=1 pred_takeM=0.
REQ-030 Same PC (ghr held 0 by not-taken history), actual_takeM=1 -> mispredM=1, E/M valid cleared next cycle, pht[0x10] 01->10, ghr=0x01, branch_cnt=1, mispred_cnt=1.
REQ-031 Three consecutive taken resolutions on one entry -> counter 11 and held at 11 on fourth taken; four not-taken -> held at 00.
REQ-032 stall=1 for 3 cycles with branch in M -> pht, ghr, counters, M register unchanged; resumes on stall=0.
REQ-033 Decode read and M write to same index in one cycle -> pred_takeD reflects old counter value.
REQ-034 Preload mispred_cnt=16'hFFFF via forced mispredictions -> further mispredM leaves 16'hFFFF; rst mid-sequence -> all counters 0, branchM=0 next cycle.
